seven_segment_scan_decoder: RTL
===============================

Name: seven_segment_scan_decoder

Overview:
- Reader for a multiplexed seven-segment display bus: samples segment lines plus one-hot digit select and decodes each digit back to a 4-bit hex nibble.
- Publishes a full multi-digit value only once the same frame has been captured on STABLE_SCANS consecutive scans.
- Used for loopback self-check of the display path and for capturing externally driven displays into the datapath.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits per frame (≥1).
- STABLE_SCANS, 2, consecutive identical frames required before publishing (≥1).

Ports:
- I_CLK  input  1  system clock, all logic on rising edge.
- I_RESET  input  1  synchronous, active-high reset.
- I_SEGMENTS  input  7  segment pattern, MSB..LSB = a,b,c,d,e,f,g; active-high (see optional feature).
- I_DIGIT_SEL  input  NUM_DIGITS  one-hot select; bit k = digit k (bit 0 = least significant nibble).
- I_STROBE  input  1  I_SEGMENTS/I_DIGIT_SEL valid this cycle.
- O_VALUE  output  4*NUM_DIGITS  published value; digit k at bits [4k+3:4k].
- O_DIGIT_VALID  output  NUM_DIGITS  per-digit legal-pattern flag for published value.
- O_VALID  output  1  one-cycle pulse when O_VALUE/O_DIGIT_VALID update.
- O_ERROR  output  1  one-cycle pulse on illegal pattern or bad select.

Behaviour:
- Reset (synchronous, I_RESET=1 at edge):
  - O_VALUE=0, O_DIGIT_VALID=0, O_VALID=0, O_ERROR=0.
  - Collect buffer and seen-mask cleared; candidate/previous frames cleared; previous marked invalid; stable count=0; pending evaluation cancelled.
  - Reset mid-frame discards partial captures.
- Decode table (pattern→nibble):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7.
  - 1111111→8, 1111011→9, 1110111→A, 0011111→B, 0001101→C, 0111101→D, 1001111→E, 1000111→F.
  - Any other pattern is illegal: nibble=0, legal=0.
- Capture (every cycle, independent of evaluation):
  - I_STROBE=1 with one-hot I_DIGIT_SEL: write nibble+legal into collect slot k and set seen[k]. A repeat of the same digit within a frame overwrites it (latest wins).
  - Illegal pattern: slot still written (legal=0) and O_ERROR pulses next cycle.
  - I_STROBE=1 with zero or multi-hot select: sample dropped, seen unchanged, O_ERROR pulses next cycle.
  - I_STROBE=0: no effect.
- Frame complete: the strobe that makes seen all-ones (cycle N).
  - At that edge the full buffer, including this sample, is copied to the candidate register.
  - seen clears the same edge, so a strobe at N+1 starts the next frame.
- Evaluation pipeline, fixed latency:
  - N+1, compare:
    - If previous is valid and candidate == previous (nibbles and legal bits): count = min(count+1, STABLE_SCANS).
    - Otherwise count=1, previous=candidate, previous marked valid.
    - publish flag = (new count == STABLE_SCANS) && (old count != STABLE_SCANS).
  - N+2, publish: if publish flag, load O_VALUE/O_DIGIT_VALID from previous and O_VALID=1 for exactly that cycle.
- Publishing happens once per distinct stable run. An unchanged display never re-pulses O_VALID.
- Back-to-back frame completions, one per cycle (NUM_DIGITS=1), are fully pipelined with no drops.
- O_VALUE holds between publishes.
- Count width: clog2(STABLE_SCANS+1); saturates.

Optional Feature:
- Macro: SEVEN_SEGMENT_ACTIVE_LOW_EN.
- Defined: I_SEGMENTS is inverted before decode (common-anode displays). The illegal/error rules apply to the inverted value.
- Undefined: I_SEGMENTS is decoded as-is (active-high).
- No other behaviour changes.

Test Plan:
- Reset, then scan digits 0..3 with 1111110, 0110000, 1101101, 1111001 twice (STABLE_SCANS=2) → single O_VALID pulse 2 cycles after the 2nd frame's last strobe; O_VALUE=16'h3210, O_DIGIT_VALID=4'hF; a third identical scan → no pulse.
- Stable 16'h3210 published, then digit 2 changes to 1000111 for two scans → O_VALID after second changed frame, O_VALUE=16'h3F10; after only one changed frame → no pulse.
- Digit 1 = 0000001 (illegal) for two scans → O_ERROR pulse each occurrence; published O_DIGIT_VALID=4'b1101, nibble 1 = 0.
- Strobe with I_DIGIT_SEL=4'b0110 mid-frame → O_ERROR pulse; sample ignored; frame completes normally with remaining strobes; value unaffected.
- Assert I_RESET after 3 of 4 digits of a second matching scan → no O_VALID; all outputs 0; two fresh scans of 16'h9876 required before publish.
- With SEVEN_SEGMENT_ACTIVE_LOW_EN defined, drive 1001111 (inverted "1") on all digits twice → O_VALUE=16'h1111, no O_ERROR.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_decoder
// Purpose  : Reads a multiplexed seven-segment display bus (segment lines
//            plus one-hot digit select), decodes every digit back to a hex
//            nibble, and publishes the full multi-digit value once the same
//            frame has been seen on STABLE_SCANS consecutive scans.
// Ports    : I_CLK          rising-edge clock
//            I_RESET        synchronous active-high reset
//            I_SEGMENTS     segment pattern a..g (MSB..LSB)
//            I_DIGIT_SEL    one-hot digit select, bit k = digit k
//            I_STROBE       segments/select valid this cycle
//            O_VALUE        published value, digit k at [4k+3:4k]
//            O_DIGIT_VALID  per-digit legal-pattern flags of O_VALUE
//            O_VALID        one-cycle pulse when O_VALUE updates
//            O_ERROR        one-cycle pulse on illegal pattern / bad select
// Options  : SEVEN_SEGMENT_ACTIVE_LOW_EN - invert segments before decode
//            (common-anode displays).
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_decoder #(
    parameter int NUM_DIGITS   = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic                    I_CLK,
    input  logic                    I_RESET,
    input  logic [6:0]              I_SEGMENTS,
    input  logic [NUM_DIGITS-1:0]   I_DIGIT_SEL,
    input  logic                    I_STROBE,
    output logic [4*NUM_DIGITS-1:0] O_VALUE,
    output logic [NUM_DIGITS-1:0]   O_DIGIT_VALID,
    output logic                    O_VALID,
    output logic                    O_ERROR
);

    localparam int                      c_cnt_w    = $clog2(STABLE_SCANS + 1);
    localparam logic [c_cnt_w-1:0]      c_stable   = c_cnt_w'(STABLE_SCANS);
    localparam logic [c_cnt_w-1:0]      c_cnt_one  = c_cnt_w'(1);
    localparam logic [NUM_DIGITS-1:0]   c_sel_one  = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0]   c_all_seen = '1;

    // Returns {legal, nibble}; unknown patterns decode to {0, 4'h0}.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: f_decode = 5'h10;
            7'b0110000: f_decode = 5'h11;
            7'b1101101: f_decode = 5'h12;
            7'b1111001: f_decode = 5'h13;
            7'b0110011: f_decode = 5'h14;
            7'b1011011: f_decode = 5'h15;
            7'b1011111: f_decode = 5'h16;
            7'b1110000: f_decode = 5'h17;
            7'b1111111: f_decode = 5'h18;
            7'b1111011: f_decode = 5'h19;
            7'b1110111: f_decode = 5'h1A;
            7'b0011111: f_decode = 5'h1B;
            7'b0001101: f_decode = 5'h1C;
            7'b0111101: f_decode = 5'h1D;
            7'b1001111: f_decode = 5'h1E;
            7'b1000111: f_decode = 5'h1F;
            default:    f_decode = 5'h00;
        endcase
    endfunction

    logic [6:0]              w_seg;
    logic [4:0]              w_dec;
    logic [3:0]              w_nib;
    logic                    w_legal;
    logic                    w_one_hot;
    logic                    w_capture;
    logic                    w_frame_done;
    logic [4*NUM_DIGITS-1:0] w_merged_value;
    logic [NUM_DIGITS-1:0]   w_merged_legal;
    logic                    w_same;
    logic [c_cnt_w-1:0]      w_next_cnt;

    // Collect buffer for the frame being scanned
    logic [4*NUM_DIGITS-1:0] r_col_value;
    logic [NUM_DIGITS-1:0]   r_col_legal;
    logic [NUM_DIGITS-1:0]   r_seen;
    // Completed frame awaiting comparison
    logic [4*NUM_DIGITS-1:0] r_cand_value;
    logic [NUM_DIGITS-1:0]   r_cand_legal;
    logic                    r_eval;
    // Reference frame of the current stable run
    logic [4*NUM_DIGITS-1:0] r_prev_value;
    logic [NUM_DIGITS-1:0]   r_prev_legal;
    logic                    r_prev_ok;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_publish;
    // Output registers
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_digit_valid;
    logic                    r_valid;
    logic                    r_error;

`ifdef SEVEN_SEGMENT_ACTIVE_LOW_EN
    assign w_seg = ~I_SEGMENTS;
`else
    assign w_seg = I_SEGMENTS;
`endif

    assign w_dec     = f_decode(w_seg);
    assign w_nib     = w_dec[3:0];
    assign w_legal   = w_dec[4];
    assign w_one_hot = (I_DIGIT_SEL != '0) &&
                       ((I_DIGIT_SEL & (I_DIGIT_SEL - c_sel_one)) == '0);
    assign w_capture = I_STROBE && w_one_hot;

    // Buffer contents as they will be after this sample is written; used both
    // for the buffer update and for the candidate copy on frame completion so
    // the completing sample is included.
    always_comb begin
        w_merged_value = r_col_value;
        w_merged_legal = r_col_legal;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (I_DIGIT_SEL[k]) begin
                w_merged_value[4*k +: 4] = w_nib;
                w_merged_legal[k]        = w_legal;
            end
        end
    end

    assign w_frame_done = w_capture && ((r_seen | I_DIGIT_SEL) == c_all_seen);

    assign w_same     = r_prev_ok && (r_cand_value == r_prev_value) &&
                        (r_cand_legal == r_prev_legal);
    assign w_next_cnt = !w_same          ? c_cnt_one :
                        (r_cnt == c_stable) ? r_cnt : r_cnt + c_cnt_one;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_col_value   <= '0;
            r_col_legal   <= '0;
            r_seen        <= '0;
            r_cand_value  <= '0;
            r_cand_legal  <= '0;
            r_eval        <= 1'b0;
            r_prev_value  <= '0;
            r_prev_legal  <= '0;
            r_prev_ok     <= 1'b0;
            r_cnt         <= '0;
            r_publish     <= 1'b0;
            r_value       <= '0;
            r_digit_valid <= '0;
            r_valid       <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            // Bad select and illegal pattern both flag; bad select drops sample.
            r_error <= I_STROBE && !(w_one_hot && w_legal);

            if (w_capture) begin
                r_col_value <= w_merged_value;
                r_col_legal <= w_merged_legal;
                r_seen      <= w_frame_done ? '0 : (r_seen | I_DIGIT_SEL);
            end

            r_eval <= w_frame_done;
            if (w_frame_done) begin
                r_cand_value <= w_merged_value;
                r_cand_legal <= w_merged_legal;
            end

            // Compare stage; publish only on the transition into saturation
            // so an unchanged display never pulses again.
            r_publish <= 1'b0;
            if (r_eval) begin
                r_cnt     <= w_next_cnt;
                r_publish <= (w_next_cnt == c_stable) && (r_cnt != c_stable);
                if (!w_same) begin
                    r_prev_value <= r_cand_value;
                    r_prev_legal <= r_cand_legal;
                    r_prev_ok    <= 1'b1;
                end
            end

            // Publish stage; previous already holds the frame that saturated.
            r_valid <= r_publish;
            if (r_publish) begin
                r_value       <= r_prev_value;
                r_digit_valid <= r_prev_legal;
            end
        end
    end

    assign O_VALUE       = r_value;
    assign O_DIGIT_VALID = r_digit_valid;
    assign O_VALID       = r_valid;
    assign O_ERROR       = r_error;

endmodule
`default_nettype wire
